dmem_access_ctrl: RTL and testbench

Sequencer between the MEM pipeline stage and the word-organised data memory. Accepts RV32IM load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW). Performs lane extraction and sign/zero extension for loads. Turns byte and halfword stores into a read-modify-write pair, because the memory only writes whole words. Drives the memory's `address`/`writeData`/`memWrite`/`memRead` pins and returns `req_ready` to the hazard unit as the MEM-stage stall source.

---
 rtl/dmem_access_ctrl_if.sv | 38 +++
 rtl/dmem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the MEM-stage request/response handshake and the data-memory pins.
// Latency: none, wires only.
// Backpressure: req_ready from the controller; the memory side has no stall.
//
// Modports:
//   slave  - the controller. It takes requests and memory read data, and drives
//            responses and memory pins.
//   master - the environment: the MEM stage plus the memory itself.
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_misaligned;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_writeData;
   logic              mem_memWrite;
   logic              mem_memRead;
   logic [31:0]       mem_readData;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_readData,
      output req_ready, resp_valid, resp_rdata, resp_misaligned,
             mem_address, mem_writeData, mem_memWrite, mem_memRead
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_readData,
      input  req_ready, resp_valid, resp_rdata, resp_misaligned,
             mem_address, mem_writeData, mem_memWrite, mem_memRead
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide data memory.
// Latency: load/SW respond in cycle 2, SB/SH (read-modify-write) in cycle 3, illegal/fault in cycle 1.
// Backpressure: req_ready is high only in IDLE with reset released, and it stalls the MEM stage.
//
// Ports: clk, reset (synchronous, active low), bus (dmem_access_ctrl_if.slave).
//   The request side is req_valid/ready/write/funct3/addr/wdata.
//   The response side is resp_valid/rdata/misaligned.
//   The memory side is mem_address/writeData/memWrite/memRead/readData.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
module dmem_access_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   dmem_access_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, ST_WR, RMW_RD, RMW_WR, RESP} state_t;

   state_t            state, state_nxt;
   // The op type (load/store) is carried by the state, so only the
   // operand fields are latched.
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic [31:0]       wdata_q;
   logic [31:0]       old_q;
   logic [31:0]       rdata_q;

   logic              accept, illegal, fault;
   logic              rd_en, wr_en;
   logic [31:0]       wr_word, load_val, merged;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;

   assign bus.req_ready = (state == IDLE) && reset;
   assign accept        = bus.req_valid && bus.req_ready;

   // Stores only have B/H/W. Loads add BU/HU.
   always_comb begin
      illegal = 1'b0;
      if (bus.req_write)
         illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
      else
         illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   logic mis_q;
   // funct3[1:0] is 01 for H/HU and 10 for W. Illegal ops take priority.
   assign fault = !illegal &&
                  (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
   assign bus.resp_misaligned = mis_q;
`else
   assign fault               = 1'b0;
   assign bus.resp_misaligned = 1'b0;
`endif

   // Lane extraction for loads. It works directly on the asynchronous read data.
   always_comb begin
      lane_byte = 8'h00;
      load_val  = bus.mem_readData;
      case (addr_q[1:0])
         2'd0:    lane_byte = bus.mem_readData[7:0];
         2'd1:    lane_byte = bus.mem_readData[15:8];
         2'd2:    lane_byte = bus.mem_readData[23:16];
         default: lane_byte = bus.mem_readData[31:24];
      endcase
      lane_half = addr_q[1] ? bus.mem_readData[31:16] : bus.mem_readData[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_val = {24'h0, lane_byte};
         3'b101:  load_val = {16'h0, lane_half};
         default: load_val = bus.mem_readData;
      endcase
   end

   // Store merge into the old word captured in RMW_RD. SB is f3 000 and SH is 001.
   always_comb begin
      merged = old_q;
      if (f3_q[0]) begin
         if (addr_q[1]) merged[31:16] = wdata_q[15:0];
         else           merged[15:0]  = wdata_q[15:0];
      end else begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      wr_word   = 32'h0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (illegal || fault)              state_nxt = RESP;
               else if (!bus.req_write)           state_nxt = LOAD;
               else if (bus.req_funct3 == 3'b010) state_nxt = ST_WR;
               else                               state_nxt = RMW_RD;
            end
         end
         LOAD:   begin rd_en = 1'b1; state_nxt = RESP; end
         ST_WR:  begin wr_en = 1'b1; wr_word = wdata_q; state_nxt = RESP; end
         RMW_RD: begin rd_en = 1'b1; state_nxt = RMW_WR; end
         RMW_WR: begin wr_en = 1'b1; wr_word = merged; state_nxt = RESP; end
         RESP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The strobes are gated by reset, so a reset cycle never writes memory.
   assign bus.mem_memRead   = rd_en && reset;
   assign bus.mem_memWrite  = wr_en && reset;
   assign bus.mem_writeData = bus.mem_memWrite ? wr_word : 32'h0;
   assign bus.mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.resp_valid    = (state == RESP) && reset;
   assign bus.resp_rdata    = rdata_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q  <= bus.req_addr;
            f3_q    <= bus.req_funct3;
            wdata_q <= bus.req_wdata;
         end
         if (state == RMW_RD) old_q <= bus.mem_readData;
         // Response fields change only on entry to RESP and then hold.
         if (state_nxt == RESP) begin
            rdata_q <= (state == LOAD) ? load_val : 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
            mis_q   <= (state == IDLE) && fault;
`endif
         end
      end
   end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl.
// It has a word memory model plus a reference model of load/store semantics.
// It covers directed scenarios followed by a randomized op stream.
module tb_dmem_access_ctrl;
   localparam int ADDR_W = 32;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   both_cnt = 0;

   dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
   dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Memory: asynchronous read and write on the rising edge. It can be preloaded through pl_*.
   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_dat;

   assign bus.mem_readData = mem[bus.mem_address[7:2]];
   always @(posedge clk) begin
      if (bus.mem_memWrite) mem[bus.mem_address[7:2]] <= bus.mem_writeData;
      else if (pl_en)       mem[pl_idx] <= pl_dat;
   end
   always @(negedge clk) if (bus.mem_memRead && bus.mem_memWrite) both_cnt++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic preload(input int idx, input logic [31:0] d);
      pl_en = 1'b1; pl_idx = idx[5:0]; pl_dat = d; ref_mem[idx] = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Issue one request and trace the cycles (relative to the accept edge) of the read, write and response.
   task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic mis, output int resp_cyc,
                         output int rd_cyc, output int wr_cyc, output int n_wr, output logic [31:0] wr_dat);
      rdata = '0; mis = 1'b0; resp_cyc = -1; rd_cyc = -1; wr_cyc = -1; n_wr = 0; wr_dat = '0;
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (bus.mem_memRead && rd_cyc < 0) rd_cyc = c;
         if (bus.mem_memWrite) begin n_wr++; wr_cyc = c; wr_dat = bus.mem_writeData; end
         if (bus.resp_valid) begin
            resp_cyc = c; rdata = bus.resp_rdata; mis = bus.resp_misaligned;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   // Reference: the RV32 load/store semantics, from the access size and byte offset.
   task automatic model_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] e_rdata, output logic e_mis, output int e_resp,
                           output int e_rd, output int e_wr, output logic [31:0] e_wdat);
      int          idx, size, off, sh;
      bit          legal, bad;
      logic [31:0] word, m32, v;
      longint unsigned mask;
      idx  = int'(addr[7:2]);
      word = ref_mem[idx];
      legal = wr ? (f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      size = (f3 == 3'b000 || f3 == 3'b100) ? 1 : ((f3 == 3'b001 || f3 == 3'b101) ? 2 : 4);
      bad  = CHK && legal && ((int'(addr[1:0]) % size) != 0);
      off  = (size == 1) ? int'(addr[1:0]) : ((size == 2) ? int'(addr[1:0]) / 2 * 2 : 0);
      sh   = 8 * off;
      mask = (64'd1 << (8 * size)) - 64'd1;
      m32  = mask[31:0];
      e_rdata = '0; e_mis = bad; e_rd = -1; e_wr = -1; e_wdat = '0;
      if (!legal || bad) begin
         e_resp = 1;
      end else if (!wr) begin
         v = (word >> sh) & m32;
         if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~m32;
         e_rdata = v; e_rd = 1; e_resp = 2;
      end else if (size == 4) begin
         e_wr = 1; e_wdat = wd; e_resp = 2; ref_mem[idx] = wd;
      end else begin
         v = (word & ~(m32 << sh)) | ((wd & m32) << sh);
         e_rd = 1; e_wr = 2; e_wdat = v; e_resp = 3; ref_mem[idx] = v;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({bus.req_ready, bus.resp_valid, bus.resp_misaligned, bus.mem_memRead, bus.mem_memWrite} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b required 00000", {bus.req_ready, bus.resp_valid, bus.resp_misaligned, bus.mem_memRead, bus.mem_memWrite}); end
      checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", bus.resp_rdata); end
      checks++; if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", bus.mem_address); end
      checks++; if (bus.mem_writeData !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", bus.mem_writeData); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.req_ready); end
   endtask

   task automatic test_loads();
      logic [31:0] ta [5] = '{32'h40, 32'h40, 32'h43, 32'h42, 32'h40};
      logic [2:0]  tf [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] te [5] = '{32'h80F17F82, 32'hFFFFFF82, 32'h00000080, 32'hFFFF80F1, 32'h00007F82};
      logic [31:0] rd, wdat; logic mis; int rc, rdc, wc, nw;
      preload(16, 32'h80F1_7F82);
      for (int i = 0; i < 5; i++) begin
         run_op(1'b0, tf[i], ta[i], 32'h0, rd, mis, rc, rdc, wc, nw, wdat);
         checks++; if (rd !== te[i]) begin errors++; $display("FAIL load%0d_data: got %h required %h", i, rd, te[i]); end
         checks++; if (rc != 2 || rdc != 1 || nw != 0) begin errors++; $display("FAIL load%0d_timing: got resp=%0d read=%0d writes=%0d required 2 1 0", i, rc, rdc, nw); end
         checks++; if (bus.resp_rdata !== te[i]) begin errors++; $display("FAIL load%0d_hold: got %h required %h", i, bus.resp_rdata, te[i]); end
      end
   endtask

   task automatic test_misalign();
      logic [31:0] rd, wdat; logic mis; int rc, rdc, wc, nw;
      run_op(1'b0, 3'b010, 32'h42, 32'h0, rd, mis, rc, rdc, wc, nw, wdat);
      checks++; if (mis !== CHK) begin errors++; $display("FAIL misalign_flag: got %b required %b", mis, CHK); end
      checks++; if (rc != (CHK ? 1 : 2)) begin errors++; $display("FAIL misalign_resp_cycle: got %0d required %0d", rc, CHK ? 1 : 2); end
      checks++; if (rdc != (CHK ? -1 : 1)) begin errors++; $display("FAIL misalign_read_cycle: got %0d required %0d", rdc, CHK ? -1 : 1); end
      checks++; if (rd !== (CHK ? 32'h0 : 32'h80F17F82)) begin errors++; $display("FAIL misalign_data: got %h", rd); end
   endtask

   task automatic test_illegal();
      logic [31:0] rd, wdat; logic mis; int rc, rdc, wc, nw;
      run_op(1'b0, 3'b010, 32'h40, 32'h0, rd, mis, rc, rdc, wc, nw, wdat);
      run_op(1'b0, 3'b011, 32'h40, 32'h0, rd, mis, rc, rdc, wc, nw, wdat);
      checks++; if (rc != 1 || rdc != -1 || nw != 0) begin errors++; $display("FAIL illegal_timing: got resp=%0d read=%0d writes=%0d required 1 -1 0", rc, rdc, nw); end
      checks++; if (rd !== 32'h0 || mis !== 1'b0) begin errors++; $display("FAIL illegal_resp: got %h/%b required 0/0", rd, mis); end
   endtask

   task automatic test_sb_rmw();
      logic [31:0] rd, wdat; logic mis; int rc, rdc, wc, nw;
      preload(4, 32'h1122_3344);
      run_op(1'b1, 3'b000, 32'h12, 32'h0000_00AB, rd, mis, rc, rdc, wc, nw, wdat);
      checks++; if (rdc != 1 || wc != 2 || nw != 1 || rc != 3) begin errors++; $display("FAIL sb_timing: got read=%0d write=%0d n=%0d resp=%0d required 1 2 1 3", rdc, wc, nw, rc); end
      checks++; if (wdat !== 32'h11AB_3344) begin errors++; $display("FAIL sb_merge: got %h required 11ab3344", wdat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h required 0", rd); end
      run_op(1'b0, 3'b010, 32'h10, 32'h0, rd, mis, rc, rdc, wc, nw, wdat);
      checks++; if (rd !== 32'h11AB_3344) begin errors++; $display("FAIL sb_readback: got %h required 11ab3344", rd); end
   endtask

   task automatic test_back_to_back();
      logic rdy [1:3]; logic rsp [1:3]; int nw = 0; logic w4;
      preload(8, 32'h0);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      for (int c = 1; c <= 3; c++) begin
         rdy[c] = bus.req_ready; rsp[c] = bus.resp_valid;
         if (bus.mem_memWrite) nw++;
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      w4 = bus.mem_memWrite;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({rdy[1], rdy[2], rdy[3]} !== 3'b001) begin errors++; $display("FAIL b2b_ready: got %b required 001", {rdy[1], rdy[2], rdy[3]}); end
      checks++; if ({rsp[1], rsp[2], rsp[3]} !== 3'b010) begin errors++; $display("FAIL b2b_resp: got %b required 010", {rsp[1], rsp[2], rsp[3]}); end
      checks++; if (nw != 1) begin errors++; $display("FAIL b2b_write_count: got %0d required 1", nw); end
      checks++; if (w4 !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %b required 1", w4); end
      checks++; if (mem[8] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_mem: got %h required deadbeef", mem[8]); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd, wdat; logic mis; int rc, rdc, wc, nw;
      int wseen = 0, rseen = 0; logic wgate;
      preload(12, 32'hCAFE_F00D);
      run_op(1'b0, 3'b010, 32'h30, 32'h0, rd, mis, rc, rdc, wc, nw, wdat);
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL pre_reset_load: got %h required cafef00d", rd); end
      // SH abandoned in RMW_RD
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b001;
      bus.req_addr = 32'h30; bus.req_wdata = 32'h0000_1234;
      @(posedge clk); #1;
      bus.req_valid = 1'b0; reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (bus.mem_memWrite) wseen++;
         if (bus.resp_valid) rseen++;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      checks++; if ({bus.req_ready, bus.resp_valid, bus.resp_misaligned, bus.mem_memRead, bus.mem_memWrite} !== 5'b10000) begin errors++; $display("FAIL mid_reset_ctl: got %b required 10000", {bus.req_ready, bus.resp_valid, bus.resp_misaligned, bus.mem_memRead, bus.mem_memWrite}); end
      checks++; if (bus.resp_rdata !== 32'h0 || bus.mem_address !== 32'h0 || bus.mem_writeData !== 32'h0) begin errors++; $display("FAIL mid_reset_data: got %h %h %h required 0 0 0", bus.resp_rdata, bus.mem_address, bus.mem_writeData); end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (bus.mem_memWrite) wseen++;
         if (bus.resp_valid) rseen++;
      end
      // SW whose write cycle coincides with reset
      bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_wdata = 32'h0000_0BAD;
      @(posedge clk); #1;
      bus.req_valid = 1'b0; reset = 1'b0;
      #1;
      wgate = bus.mem_memWrite;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) rseen++;
      end
      reset = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.mem_memWrite) wseen++;
         if (bus.resp_valid) rseen++;
      end
      checks++; if (wseen != 0 || wgate !== 1'b0) begin errors++; $display("FAIL mid_reset_write: got writes=%0d gated=%b required 0 0", wseen, wgate); end
      checks++; if (rseen != 0) begin errors++; $display("FAIL mid_reset_resp: got %0d required 0", rseen); end
      checks++; if (mem[12] !== 32'hCAFE_F00D) begin errors++; $display("FAIL mid_reset_mem: got %h required cafef00d", mem[12]); end
   endtask

   task automatic test_random();
      logic [31:0] rd, wdat, e_rd, e_wdat, addr, wd;
      logic mis, e_mis, wr; logic [2:0] f3; logic [7:0] a8;
      int rc, rdc, wc, nw, e_rc, e_rdc, e_wc, bad_words = 0;
      for (int i = 0; i < 64; i++) preload(i, $urandom);
      for (int n = 0; n < 150; n++) begin
         wr   = 1'($urandom_range(0, 1));
         f3   = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         a8   = 8'($urandom_range(0, 255));
         addr = {24'h0, a8};
         wd   = $urandom;
         model_op(wr, f3, addr, wd, e_rd, e_mis, e_rc, e_rdc, e_wc, e_wdat);
         run_op(wr, f3, addr, wd, rd, mis, rc, rdc, wc, nw, wdat);
         checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata: wr=%b f3=%b a=%h got %h required %h", n, wr, f3, addr, rd, e_rd); end
         checks++; if (mis !== e_mis) begin errors++; $display("FAIL rnd%0d_mis: got %b required %b", n, mis, e_mis); end
         checks++; if (rc != e_rc) begin errors++; $display("FAIL rnd%0d_resp_cycle: got %0d required %0d", n, rc, e_rc); end
         checks++; if (rdc != e_rdc) begin errors++; $display("FAIL rnd%0d_read_cycle: got %0d required %0d", n, rdc, e_rdc); end
         checks++; if (wc != e_wc || nw != (e_wc > 0 ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_write_cycle: got %0d (n=%0d) required %0d", n, wc, nw, e_wc); end
         checks++; if (wdat !== e_wdat) begin errors++; $display("FAIL rnd%0d_wdata: got %h required %h", n, wdat, e_wdat); end
      end
      for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad_words++;
      checks++; if (bad_words != 0) begin errors++; $display("FAIL rnd_mem_image: got %0d differing words required 0", bad_words); end
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL read_write_overlap: got %0d cycles required 0", both_cnt); end
   endtask

   initial begin
      reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
      bus.req_addr = '0; bus.req_wdata = '0;
      pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
      @(posedge clk); #1;
      test_reset();
      test_loads();
      test_misalign();
      test_illegal();
      test_sb_rmw();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
